// File: rtl/regfile_writeback.sv
// Write-side controller for a 2R/1W register file with hard-wired $0.
// Single-cycle ALU results go straight to the registered write stage.
// Deferred (load/mul-div) results wait in an in-order FIFO and take
// the write port whenever the ALU does not need it.
// A per-register pending mask lets issue logic stall RAW hazards.
module regfile_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDR_W-1:0]       alu_wa,
  input  logic [DATA_W-1:0]       alu_wd,
  input  logic                    lsu_valid,
  output logic                    lsu_ready,
  input  logic [ADDR_W-1:0]       lsu_wa,
  input  logic [DATA_W-1:0]       lsu_wd,
  output logic                    rf_we,
  output logic [ADDR_W-1:0]       rf_wa,
  output logic [DATA_W-1:0]       rf_wd,
  output logic [2**ADDR_W-1:0]    pending,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 2**ADDR_W;

  // Deferred-result storage; only the pointers and count carry reset.
  logic [ADDR_W-1:0] wa_mem [DEPTH];
  logic [DATA_W-1:0] wd_mem [DEPTH];

  logic [PW-1:0]     rd_ptr_reg;
  logic [PW-1:0]     wr_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;

  logic              rf_we_reg;
  logic [ADDR_W-1:0] rf_wa_reg;
  logic [DATA_W-1:0] rf_wd_reg;

  logic              not_full;
  logic              alu_write;
  logic              push;
  logic              pop;
  logic [DEPTH-1:0]  entry_valid;
  logic [NREG-1:0]   fifo_pend;

  // Full is judged on the registered count only, so a pop in the same
  // cycle never makes room for an extra push.
  assign not_full  = (count_reg < CW'(DEPTH));
  assign lsu_ready = not_full;

  // The ALU may not overtake a queued write to the same register, and is
  // held off entirely while the FIFO is full so the queue can drain.
  assign alu_ready = not_full && !fifo_pend[alu_wa];

  // Writes to $0 are accepted but never occupy the write port or the FIFO.
  assign alu_write = alu_valid && alu_ready && (alu_wa != '0);
  assign push      = lsu_valid && lsu_ready && (lsu_wa != '0);
  assign pop       = !alu_write && (count_reg != '0);

  assign count_next = count_reg + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

  // An entry is live when its distance from the read pointer is below the count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_valid
      logic [PW-1:0] offset;
      assign offset          = PW'(gi) - rd_ptr_reg;
      assign entry_valid[gi] = ({1'b0, offset} < count_reg);
    end
  endgenerate

  // Destination mask of every live FIFO entry.
  always_comb begin
    fifo_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        fifo_pend[wa_mem[i]] = 1'b1;
      end
    end
  end

  // Scoreboard: queued in the FIFO or sitting in the output stage; $0 never pends.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_pending
      if (gi == 0) begin : g_zero
        assign pending[gi] = 1'b0;
      end else begin : g_reg
        assign pending[gi] = fifo_pend[gi] ||
                             (rf_we_reg && (rf_wa_reg == ADDR_W'(gi)));
      end
    end
  endgenerate

  // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // FIFO storage write at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      wa_mem[wr_ptr_reg] <= lsu_wa;
      wd_mem[wr_ptr_reg] <= lsu_wd;
    end
  end

  // Output stage: ALU has priority, else FIFO head, else idle holding addr/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_reg <= 1'b0;
      rf_wa_reg <= '0;
      rf_wd_reg <= '0;
    end else if (alu_write) begin
      rf_we_reg <= 1'b1;
      rf_wa_reg <= alu_wa;
      rf_wd_reg <= alu_wd;
    end else if (pop) begin
      rf_we_reg <= 1'b1;
      rf_wa_reg <= wa_mem[rd_ptr_reg];
      rf_wd_reg <= wd_mem[rd_ptr_reg];
    end else begin
      rf_we_reg <= 1'b0;
    end
  end

  assign rf_we      = rf_we_reg;
  assign rf_wa      = rf_wa_reg;
  assign rf_wd      = rf_wd_reg;
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: a directed table of per-cycle vectors
// followed by randomized traffic checked against a queue-based model.
module tb_regfile_writeback;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_wa;
  logic [31:0] lsu_wd;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] pending;
  logic [2:0]  fifo_count;

  int n_vec = 0;
  int n_err = 0;

  regfile_writeback #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wa(lsu_wa), .lsu_wd(lsu_wd),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .pending(pending), .fifo_count(fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  awa;
    logic [31:0] awd;
    logic        lv;
    logic [4:0]  lwa;
    logic [31:0] lwd;
    logic        e_ar;
    logic        e_lr;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [2:0]  e_cnt;
    logic [31:0] e_pend;
  } vec_t;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  localparam int NROWS = 36;
  vec_t tbl [NROWS];

  function automatic vec_t mk(input logic r, input logic av, input logic [4:0] awa,
                              input logic [31:0] awd, input logic lv, input logic [4:0] lwa,
                              input logic [31:0] lwd, input logic ear, input logic elr,
                              input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                              input logic [2:0] ecnt, input logic [31:0] epend);
    vec_t v;
    v.rst = r; v.av = av; v.awa = awa; v.awd = awd;
    v.lv = lv; v.lwa = lwa; v.lwd = lwd;
    v.e_ar = ear; v.e_lr = elr; v.e_we = ewe; v.e_wa = ewa;
    v.e_wd = ewd; v.e_cnt = ecnt; v.e_pend = epend;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ear, input logic elr, input logic ewe,
                           input logic [4:0] ewa, input logic [31:0] ewd,
                           input logic [2:0] ecnt, input logic [31:0] epend);
    chk({tag, " alu_ready"},  {31'b0, alu_ready}, {31'b0, ear});
    chk({tag, " lsu_ready"},  {31'b0, lsu_ready}, {31'b0, elr});
    chk({tag, " rf_we"},      {31'b0, rf_we},     {31'b0, ewe});
    chk({tag, " rf_wa"},      {27'b0, rf_wa},     {27'b0, ewa});
    chk({tag, " rf_wd"},      rf_wd,              ewd);
    chk({tag, " fifo_count"}, {29'b0, fifo_count}, {29'b0, ecnt});
    chk({tag, " pending"},    pending,            epend);
  endtask

  // Queue-based reference model state.
  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  initial begin
    // Rows: rst av awa awd lv lwa lwd | alu_ready lsu_ready rf_we rf_wa rf_wd count pending
    // Reset state
    tbl[0]  = mk(0,0,0,0,0,0,0,                      1,1,0,0,0,0,0);
    // Single ALU write
    tbl[1]  = mk(0,1,3,32'hDEADBEEF,0,0,0,           1,1,0,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,0,0,0,                      1,1,1,3,32'hDEADBEEF,0,32'h8);
    tbl[3]  = mk(0,0,0,0,0,0,0,                      1,1,0,3,32'hDEADBEEF,0,0);
    // ALU keeps the port, LSU waits, then drains
    tbl[4]  = mk(0,1,7,32'h70,1,5,32'h11,            1,1,0,3,32'hDEADBEEF,0,0);
    tbl[5]  = mk(0,1,7,32'h71,0,0,0,                 1,1,1,7,32'h70,1,32'hA0);
    tbl[6]  = mk(0,0,0,0,0,0,0,                      1,1,1,7,32'h71,1,32'hA0);
    tbl[7]  = mk(0,0,0,0,0,0,0,                      1,1,1,5,32'h11,0,32'h20);
    tbl[8]  = mk(0,0,0,0,0,0,0,                      1,1,0,5,32'h11,0,0);
    // RAW guard on register 9
    tbl[9]  = mk(0,0,0,0,1,9,32'h99,                 1,1,0,5,32'h11,0,0);
    tbl[10] = mk(0,1,9,32'h90,0,0,0,                 0,1,0,5,32'h11,1,32'h200);
    tbl[11] = mk(0,1,9,32'h90,0,0,0,                 1,1,1,9,32'h99,0,32'h200);
    tbl[12] = mk(0,0,0,0,0,0,0,                      1,1,1,9,32'h90,0,32'h200);
    tbl[13] = mk(0,0,0,0,0,0,0,                      1,1,0,9,32'h90,0,0);
    // Fill the FIFO while the ALU streams, then drain in order
    tbl[14] = mk(0,1,10,32'hA0,1,1,32'h101,          1,1,0,9,32'h90,0,0);
    tbl[15] = mk(0,1,10,32'hA1,1,2,32'h102,          1,1,1,10,32'hA0,1,32'h402);
    tbl[16] = mk(0,1,10,32'hA2,1,3,32'h103,          1,1,1,10,32'hA1,2,32'h406);
    tbl[17] = mk(0,1,10,32'hA3,1,4,32'h104,          1,1,1,10,32'hA2,3,32'h40E);
    tbl[18] = mk(0,1,10,32'hA4,1,6,32'h106,          0,0,1,10,32'hA3,4,32'h41E);
    tbl[19] = mk(0,0,0,0,0,0,0,                      1,1,1,1,32'h101,3,32'h1E);
    tbl[20] = mk(0,0,0,0,0,0,0,                      1,1,1,2,32'h102,2,32'h1C);
    tbl[21] = mk(0,0,0,0,0,0,0,                      1,1,1,3,32'h103,1,32'h18);
    tbl[22] = mk(0,0,0,0,0,0,0,                      1,1,1,4,32'h104,0,32'h10);
    tbl[23] = mk(0,0,0,0,0,0,0,                      1,1,0,4,32'h104,0,0);
    // Writes to $0 from both sources
    tbl[24] = mk(0,1,0,32'h55,1,0,32'h66,            1,1,0,4,32'h104,0,0);
    tbl[25] = mk(0,0,0,0,0,0,0,                      1,1,0,4,32'h104,0,0);
    tbl[26] = mk(0,0,0,0,1,8,32'h88,                 1,1,0,4,32'h104,0,0);
    tbl[27] = mk(0,1,0,32'h77,0,0,0,                 1,1,0,4,32'h104,1,32'h100);
    tbl[28] = mk(0,0,0,0,0,0,0,                      1,1,1,8,32'h88,0,32'h100);
    tbl[29] = mk(0,0,0,0,0,0,0,                      1,1,0,8,32'h88,0,0);
    // Reset with three entries queued and a write in the output stage
    tbl[30] = mk(0,1,12,32'hC0,1,13,32'hD1,          1,1,0,8,32'h88,0,0);
    tbl[31] = mk(0,1,12,32'hC1,1,14,32'hD2,          1,1,1,12,32'hC0,1,32'h3000);
    tbl[32] = mk(0,1,12,32'hC2,1,15,32'hD3,          1,1,1,12,32'hC1,2,32'h7000);
    tbl[33] = mk(1,1,12,32'hC3,1,16,32'hD4,          1,1,1,12,32'hC2,3,32'hF000);
    tbl[34] = mk(0,0,0,0,0,0,0,                      1,1,0,0,0,0,0);
    tbl[35] = mk(0,0,0,0,0,0,0,                      1,1,0,0,0,0,0);

    rst = 1'b1; alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
    lsu_valid = 1'b0; lsu_wa = '0; lsu_wd = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Directed table, one row per clock cycle.
    for (int i = 0; i < NROWS; i++) begin
      rst = tbl[i].rst;
      alu_valid = tbl[i].av; alu_wa = tbl[i].awa; alu_wd = tbl[i].awd;
      lsu_valid = tbl[i].lv; lsu_wa = tbl[i].lwa; lsu_wd = tbl[i].lwd;
      #4;
      check_all($sformatf("row%0d", i), tbl[i].e_ar, tbl[i].e_lr, tbl[i].e_we,
                tbl[i].e_wa, tbl[i].e_wd, tbl[i].e_cnt, tbl[i].e_pend);
      $display("row %0d: rf_we=%0b rf_wa=%0d rf_wd=%h count=%0d pending=%h",
               i, rf_we, rf_wa, rf_wd, fifo_count, pending);
      @(posedge clk); #1;
    end

    // Randomized traffic against the reference model, starting from reset state.
    q.delete();
    m_we = 1'b0; m_wa = '0; m_wd = '0;
    for (int c = 0; c < 3000; c++) begin
      logic        e_lr;
      logic        e_ar;
      logic        hit;
      logic [31:0] e_pend;
      ent_t        e;

      rst       = ($urandom_range(0, 99) == 0);
      alu_valid = ($urandom_range(0, 99) < 60);
      alu_wa    = 5'($urandom_range(0, 7));
      alu_wd    = $urandom;
      lsu_valid = ($urandom_range(0, 99) < 50);
      lsu_wa    = 5'($urandom_range(0, 7));
      lsu_wd    = $urandom;
      #4;

      e_lr = (q.size() < 4);
      hit  = 1'b0;
      foreach (q[k]) if (q[k].wa == alu_wa) hit = 1'b1;
      e_ar = e_lr && !hit;
      e_pend = '0;
      foreach (q[k]) e_pend[q[k].wa] = 1'b1;
      if (m_we) e_pend[m_wa] = 1'b1;
      e_pend[0] = 1'b0;

      check_all($sformatf("rnd%0d", c), e_ar, e_lr, m_we, m_wa, m_wd,
                3'(q.size()), e_pend);
      if (rst) $display("rnd %0d: reset applied with %0d queued", c, q.size());

      if (rst) begin
        q.delete();
        m_we = 1'b0; m_wa = '0; m_wd = '0;
      end else begin
        if (alu_valid && e_ar && alu_wa != 0) begin
          m_we = 1'b1; m_wa = alu_wa; m_wd = alu_wd;
        end else if (q.size() > 0) begin
          e = q.pop_front();
          m_we = 1'b1; m_wa = e.wa; m_wd = e.wd;
        end else begin
          m_we = 1'b0;
        end
        if (lsu_valid && e_lr && lsu_wa != 0) begin
          e.wa = lsu_wa; e.wd = lsu_wd;
          q.push_back(e);
        end
      end
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
